// File: rtl/mont_pkg.sv
// Shared types and constants for the Montgomery modular-exponentiation controller.
package mont_pkg;

  localparam int MM_COUNT_W = 16;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    XT_ISSUE,
    XT_WAIT,
    SQ_ISSUE,
    SQ_WAIT,
    MUL_ISSUE,
    MUL_WAIT,
    NEXT,
    OUT_ISSUE,
    OUT_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/mont_exp_scan.sv
// Exponent scanner: walks the captured exponent from bit e_len-1 down to bit 0.
module mont_exp_scan #(
  parameter int EXP_WIDTH = 1024,
  parameter int LEN_W     = $clog2(EXP_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 dec,
  input  logic [EXP_WIDTH-1:0] e,
  input  logic [LEN_W-1:0]     len,
  output logic                 cur_bit,
  output logic                 last
);

  logic [LEN_W-1:0]     idx;
  logic [EXP_WIDTH-1:0] shifted;

  // A zero length parks the index at 0; the controller never scans in that case.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (load) begin
      idx <= (len == '0) ? '0 : len - LEN_W'(1);
    end else if (dec && idx != '0) begin
      idx <= idx - LEN_W'(1);
    end
  end

  assign shifted = e >> idx;
  assign cur_bit = shifted[0];
  assign last    = (idx == '0);

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply controller driving an external Montgomery multiplier.
// Define MONT_EXP_CONST_TIME_EN to always multiply after each square (result discarded on 0 bits).
module mont_exp_ctrl
  import mont_pkg::*;
#(
  parameter int WIDTH     = 1024,
  parameter int EXP_WIDTH = 1024,
  parameter int LEN_W     = $clog2(EXP_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      x,
  input  logic [EXP_WIDTH-1:0]  e,
  input  logic [LEN_W-1:0]      e_len,
  input  logic [WIDTH-1:0]      n,
  input  logic [WIDTH-1:0]      r2n,
  input  logic [WIDTH-1:0]      rmodn,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [WIDTH-1:0]      result,
  output logic [MM_COUNT_W-1:0] mm_count,
  output logic                  mm_start,
  output logic [WIDTH-1:0]      mm_a,
  output logic [WIDTH-1:0]      mm_b,
  output logic [WIDTH-1:0]      mm_m,
  input  logic                  mm_done,
  input  logic [WIDTH-1:0]      mm_result
);

  state_t state, state_next;

  logic [WIDTH-1:0]     x_r, n_r, r2n_r, rmodn_r, a_r, xt_r;
  logic [EXP_WIDTH-1:0] e_r;
  logic [LEN_W-1:0]     e_len_r;
  logic                 len_err;
  logic                 scan_load, scan_dec, cur_bit, last;

  assign len_err = (e_len_r > LEN_W'(EXP_WIDTH));
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign mm_m    = n_r;

  mont_exp_scan #(
    .EXP_WIDTH (EXP_WIDTH),
    .LEN_W     (LEN_W)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .load    (scan_load),
    .dec     (scan_dec),
    .e       (e_r),
    .len     (e_len_r),
    .cur_bit (cur_bit),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Operands depend only on state and registers that change at WAIT completion,
  // so they stay stable from mm_start until mm_done.
  always_comb begin
    state_next = state;
    mm_start   = 1'b0;
    mm_a       = '0;
    mm_b       = '0;
    scan_load  = 1'b0;
    scan_dec   = 1'b0;
    case (state)
      IDLE:      if (start) state_next = LOAD;
      LOAD: begin
        scan_load  = 1'b1;
        state_next = len_err ? DONE : XT_ISSUE;
      end
      XT_ISSUE: begin
        mm_start   = 1'b1;
        mm_a       = x_r;
        mm_b       = r2n_r;
        state_next = XT_WAIT;
      end
      XT_WAIT: begin
        mm_a = x_r;
        mm_b = r2n_r;
        if (mm_done) state_next = (e_len_r == '0) ? OUT_ISSUE : SQ_ISSUE;
      end
      SQ_ISSUE: begin
        mm_start   = 1'b1;
        mm_a       = a_r;
        mm_b       = a_r;
        state_next = SQ_WAIT;
      end
      SQ_WAIT: begin
        mm_a = a_r;
        mm_b = a_r;
`ifdef MONT_EXP_CONST_TIME_EN
        if (mm_done) state_next = MUL_ISSUE;
`else
        if (mm_done) state_next = cur_bit ? MUL_ISSUE : NEXT;
`endif
      end
      MUL_ISSUE: begin
        mm_start   = 1'b1;
        mm_a       = a_r;
        mm_b       = xt_r;
        state_next = MUL_WAIT;
      end
      MUL_WAIT: begin
        mm_a = a_r;
        mm_b = xt_r;
        if (mm_done) state_next = NEXT;
      end
      NEXT: begin
        if (last) begin
          state_next = OUT_ISSUE;
        end else begin
          scan_dec   = 1'b1;
          state_next = SQ_ISSUE;
        end
      end
      OUT_ISSUE: begin
        mm_start   = 1'b1;
        mm_a       = a_r;
        mm_b       = WIDTH'(1);
        state_next = OUT_WAIT;
      end
      OUT_WAIT: begin
        mm_a = a_r;
        mm_b = WIDTH'(1);
        if (mm_done) state_next = DONE;
      end
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Gating MUL writeback on the current bit lets the constant-time build discard zero-bit products.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r      <= '0;
      e_r      <= '0;
      e_len_r  <= '0;
      n_r      <= '0;
      r2n_r    <= '0;
      rmodn_r  <= '0;
      a_r      <= '0;
      xt_r     <= '0;
      result   <= '0;
      mm_count <= '0;
      error    <= 1'b0;
    end else begin
      if (mm_start) mm_count <= mm_count + MM_COUNT_W'(1);
      case (state)
        IDLE: begin
          if (start) begin
            x_r     <= x;
            e_r     <= e;
            e_len_r <= e_len;
            n_r     <= n;
            r2n_r   <= r2n;
            rmodn_r <= rmodn;
          end
        end
        LOAD: begin
          a_r      <= rmodn_r;
          mm_count <= '0;
          error    <= len_err;
          if (len_err) result <= '0;
        end
        XT_WAIT:  if (mm_done) xt_r <= mm_result;
        SQ_WAIT:  if (mm_done) a_r <= mm_result;
        MUL_WAIT: if (mm_done && cur_bit) a_r <= mm_result;
        OUT_WAIT: if (mm_done) result <= mm_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench for mont_exp_ctrl with a behavioural Montgomery multiplier and a result scoreboard.
// Honours MONT_EXP_CONST_TIME_EN when predicting mm_count.
module tb_mont_exp_ctrl;

  localparam int WIDTH     = 16;
  localparam int EXP_WIDTH = 16;
  localparam int LEN_W     = $clog2(EXP_WIDTH + 1);

  logic                 clk = 1'b0;
  logic                 reset, start;
  logic [WIDTH-1:0]     x, n, r2n, rmodn;
  logic [EXP_WIDTH-1:0] e;
  logic [LEN_W-1:0]     e_len;
  logic                 busy, done, error, mm_start, mm_done;
  logic [WIDTH-1:0]     result, mm_a, mm_b, mm_m, mm_result;
  logic [15:0]          mm_count;
  logic                 mdl_done, spur_done;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [15:0]      cnt;
    logic             err;
  } exp_t;

  exp_t             sb_q[$];
  int               errors = 0;
  int               checks = 0;
  int               start_pulses = 0;
  int               fixed_lat = 5;
  bit               rand_lat = 1'b0;
  logic [WIDTH-1:0] cur_n = WIDTH'(1009);

  assign mm_done = mdl_done | spur_done;

  always #5 clk = ~clk;

  mont_exp_ctrl #(
    .WIDTH     (WIDTH),
    .EXP_WIDTH (EXP_WIDTH),
    .LEN_W     (LEN_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x         (x),
    .e         (e),
    .e_len     (e_len),
    .n         (n),
    .r2n       (r2n),
    .rmodn     (rmodn),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .result    (result),
    .mm_count  (mm_count),
    .mm_start  (mm_start),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_m      (mm_m),
    .mm_done   (mm_done),
    .mm_result (mm_result)
  );

  function automatic logic [WIDTH-1:0] mont_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    longint unsigned t = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i]) t += 64'(b);
      if (t[0]) t += 64'(m);
      t >>= 1;
    end
    if (t >= 64'(m)) t -= 64'(m);
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] ref_modexp(input logic [WIDTH-1:0] xi, input logic [EXP_WIDTH-1:0] ei,
                                                 input logic [LEN_W-1:0] li, input logic [WIDTH-1:0] ni);
    longint unsigned r = 1;
    longint unsigned b = 64'(xi) % 64'(ni);
    for (int i = int'(li) - 1; i >= 0; i--) begin
      r = (r * r) % 64'(ni);
      if (ei[i]) r = (r * b) % 64'(ni);
    end
    r = r % 64'(ni);
    return r[WIDTH-1:0];
  endfunction

  task automatic push_expected(input logic [WIDTH-1:0] xi, input logic [EXP_WIDTH-1:0] ei,
                               input logic [LEN_W-1:0] li, input logic [WIDTH-1:0] ni);
    exp_t item;
    int   pop = 0;
    if (int'(li) > EXP_WIDTH) begin
      item.res = '0;
      item.cnt = 16'd0;
      item.err = 1'b1;
    end else begin
      for (int i = 0; i < int'(li); i++) if (ei[i]) pop++;
      item.res = ref_modexp(xi, ei, li, ni);
`ifdef MONT_EXP_CONST_TIME_EN
      item.cnt = 16'(2 * int'(li) + 2);
`else
      item.cnt = 16'(int'(li) + pop + 2);
`endif
      item.err = 1'b0;
    end
    sb_q.push_back(item);
  endtask

  task automatic drive_start(input logic [WIDTH-1:0] xi, input logic [EXP_WIDTH-1:0] ei,
                             input logic [LEN_W-1:0] li, input logic [WIDTH-1:0] ni);
    longint unsigned rr;
    cur_n = ni;
    @(negedge clk);
    x     = xi;
    e     = ei;
    e_len = li;
    n     = ni;
    rr    = (64'(1) << (2 * WIDTH)) % 64'(ni);
    r2n   = rr[WIDTH-1:0];
    rr    = (64'(1) << WIDTH) % 64'(ni);
    rmodn = rr[WIDTH-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x     = WIDTH'($urandom);
    e     = EXP_WIDTH'($urandom);
    e_len = LEN_W'($urandom);
    n     = WIDTH'($urandom);
    r2n   = WIDTH'($urandom);
    rmodn = WIDTH'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic find_issue(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (mm_start === 1'b1 && mm_count == 16'(idx)) ok = 1'b1;
    end
  endtask

  // Behavioural multiplier: sees mm_start, waits the latency, returns a one-cycle mm_done.
  initial begin
    logic [WIDTH-1:0] pa, pb;
    int               l;
    mdl_done  = 1'b0;
    mm_result = '0;
    forever begin
      @(negedge clk);
      if (mm_start === 1'b1) begin
        pa = mm_a;
        pb = mm_b;
        checks++;
        if (mm_m !== cur_n) begin
          errors++;
          $display("[TB] FAIL mm_m: got %0d expected %0d", mm_m, cur_n);
        end
        l = rand_lat ? int'($urandom_range(1, 20)) : fixed_lat;
        repeat (l) @(posedge clk);
        #1;
        mdl_done  = 1'b1;
        mm_result = mont_mul(pa, pb, cur_n);
        @(posedge clk);
        #1;
        mdl_done  = 1'b0;
      end
    end
  end

  always @(negedge clk) if (mm_start === 1'b1) start_pulses++;

  // Scoreboard: every done pulse retires the oldest expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        exp_t item;
        item = sb_q.pop_front();
        checks += 2;
        if (result !== item.res) begin
          errors++;
          $display("[TB] FAIL result: got %0d expected %0d", result, item.res);
        end
        if (mm_count !== item.cnt) begin
          errors++;
          $display("[TB] FAIL mm_count: got %0d expected %0d", mm_count, item.cnt);
        end
        if (error !== item.err) begin
          errors++;
          $display("[TB] FAIL error_flag: got %0b expected %0b", error, item.err);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks += 6;
    if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0)     begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    if (error !== 1'b0)    begin errors++; $display("[TB] FAIL reset_error: got %b expected 0", error); end
    if (mm_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_mm_start: got %b expected 0", mm_start); end
    if (result !== '0)     begin errors++; $display("[TB] FAIL reset_result: got %0d expected 0", result); end
    if (mm_count !== '0)   begin errors++; $display("[TB] FAIL reset_mm_count: got %0d expected 0", mm_count); end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_example();
    bit ok;
    int cyc;
    fixed_lat = 5;
    push_expected(WIDTH'(2), EXP_WIDTH'(10), LEN_W'(4), WIDTH'(1009));
    drive_start(WIDTH'(2), EXP_WIDTH'(10), LEN_W'(4), WIDTH'(1009));
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL example_busy: got %b expected 1", busy); end
    wait_done(500, ok, cyc);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL example_timeout: got no done expected done"); end
    @(negedge clk);
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL example_done_pulse: got %b expected 0", done); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL example_busy_fall: got %b expected 0", busy); end
  endtask

  task automatic test_zero_exp();
    bit ok;
    int cyc;
    push_expected(WIDTH'(3), EXP_WIDTH'(0), LEN_W'(0), WIDTH'(1009));
    drive_start(WIDTH'(3), EXP_WIDTH'(0), LEN_W'(0), WIDTH'(1009));
    wait_done(200, ok, cyc);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL zero_exp_timeout: got no done expected done"); end
  endtask

  task automatic test_len_error();
    bit ok;
    int cyc;
    int pulses_before;
    pulses_before = start_pulses;
    push_expected(WIDTH'(2), EXP_WIDTH'(10), LEN_W'(EXP_WIDTH + 1), WIDTH'(1009));
    drive_start(WIDTH'(2), EXP_WIDTH'(10), LEN_W'(EXP_WIDTH + 1), WIDTH'(1009));
    wait_done(2, ok, cyc);
    checks += 2;
    if (!ok) begin errors++; $display("[TB] FAIL len_error_latency: got no done within %0d cycles expected <=2", cyc); end
    if (start_pulses != pulses_before) begin
      errors++;
      $display("[TB] FAIL len_error_mm_start: got %0d pulses expected 0", start_pulses - pulses_before);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_restart_spurious();
    bit ok;
    int cyc;
    push_expected(WIDTH'(7), EXP_WIDTH'(13), LEN_W'(4), WIDTH'(1019));
    drive_start(WIDTH'(7), EXP_WIDTH'(13), LEN_W'(4), WIDTH'(1019));
    find_issue(1, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL restart_sq_issue: got no SQ issue expected one"); end
    spur_done = 1'b1;
    start     = 1'b1;
    x         = WIDTH'(5);
    e         = EXP_WIDTH'(3);
    e_len     = LEN_W'(2);
    @(negedge clk);
    spur_done = 1'b0;
    start     = 1'b0;
    wait_done(1000, ok, cyc);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL restart_timeout: got no done expected done"); end
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL restart_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    int cyc;
    int pulses_before;
    drive_start(WIDTH'(2), EXP_WIDTH'(10), LEN_W'(4), WIDTH'(1009));
    find_issue(1, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL abort_sq_issue: got no SQ issue expected one"); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks += 4;
    if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    if (result !== '0)   begin errors++; $display("[TB] FAIL abort_result: got %0d expected 0", result); end
    if (mm_count !== '0) begin errors++; $display("[TB] FAIL abort_mm_count: got %0d expected 0", mm_count); end
    if (done !== 1'b0)   begin errors++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    pulses_before = start_pulses;
    repeat (30) @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_late_done: got busy=%b expected 0", busy); end
    if (start_pulses != pulses_before) begin
      errors++;
      $display("[TB] FAIL abort_mm_start: got %0d pulses expected 0", start_pulses - pulses_before);
    end
    push_expected(WIDTH'(2), EXP_WIDTH'(10), LEN_W'(4), WIDTH'(1009));
    drive_start(WIDTH'(2), EXP_WIDTH'(10), LEN_W'(4), WIDTH'(1009));
    wait_done(500, ok, cyc);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL abort_rerun_timeout: got no done expected done"); end
  endtask

  task automatic test_random();
    bit               ok;
    int               cyc;
    logic [WIDTH-1:0]     ni, xi;
    logic [EXP_WIDTH-1:0] ei;
    logic [LEN_W-1:0]     li;
    rand_lat = 1'b1;
    for (int k = 0; k < 100; k++) begin
      ni = WIDTH'($urandom_range(3, 65535)) | WIDTH'(1);
      xi = WIDTH'($urandom) % ni;
      ei = EXP_WIDTH'($urandom);
      li = LEN_W'($urandom_range(0, EXP_WIDTH));
      push_expected(xi, ei, li, ni);
      drive_start(xi, ei, li, ni);
      wait_done(3000, ok, cyc);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL random_timeout: case %0d got no done expected done", k); end
    end
    rand_lat = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    spur_done = 1'b0;
    x         = '0;
    e         = '0;
    e_len     = '0;
    n         = '0;
    r2n       = '0;
    rmodn     = '0;
    test_reset();
    test_example();
    test_zero_exp();
    test_len_error();
    test_restart_spurious();
    test_reset_abort();
    test_random();
    repeat (5) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mont_exp_ctrl.md
MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 1024: modulus/operand width in bits.
REQ-002 SHALL have parameter EXP_WIDTH, default 1024: maximum exponent length in bits.
REQ-003 SHALL have parameter LEN_W, default $clog2(EXP_WIDTH+1): width of e_len.
REQ-004 Ports (name, direction, width, meaning), one clock, synchronous active-high reset:
  clk  in  1  single clock.
  reset  in  1  synchronous, active-high.
  start  in  1  begin exponentiation; sampled in IDLE only.
  x  in  WIDTH  base, x < n.
  e  in  EXP_WIDTH  exponent; bit e_len-1 is the MSB scanned.
  e_len  in  LEN_W  exponent bit length.
  n  in  WIDTH  odd modulus.
  r2n  in  WIDTH  R^2 mod n, with R = 2^WIDTH.
  rmodn  in  WIDTH  R mod n.
  busy  out  1  high in every state except IDLE.
  done  out  1  one-cycle pulse on completion.
  error  out  1  valid with done; high when e_len > EXP_WIDTH.
  result  out  WIDTH  x^e mod n; held until the next start is accepted.
  mm_count  out  16  number of mm_start pulses for the current operation.
  mm_start  out  1  one-cycle pulse that launches the external Montgomery multiplier.
  mm_a, mm_b, mm_m  out  WIDTH  multiplier operands, stable from mm_start until mm_done.
  mm_done  in  1  multiplier completion pulse.
  mm_result  in  WIDTH  multiplier output; valid when mm_done is high.

Function
REQ-005 On start in IDLE, SHALL capture x, e, e_len, n, r2n and rmodn into internal registers; later input changes SHALL have no effect on the operation.
REQ-006 SHALL ignore start in any state other than IDLE.
REQ-007 States: IDLE, LOAD, XT_ISSUE, XT_WAIT, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, OUT_ISSUE, OUT_WAIT, DONE.
REQ-008 IDLE -> LOAD on start. LOAD sets A = rmodn, idx = e_len-1 and mm_count = 0.
REQ-009 If e_len > EXP_WIDTH, LOAD SHALL go to DONE with error = 1 and result = 0, and SHALL issue no mm_start.
REQ-010 Each *_ISSUE state SHALL last 1 cycle, pulse mm_start and increment mm_count; the matching *_WAIT state SHALL hold until mm_done.
REQ-011 XT computes Xt = MM(x, r2n). Then, if e_len = 0, go to OUT_ISSUE; otherwise go to SQ_ISSUE.
REQ-012 SQ computes A = MM(A, A). Then go to MUL_ISSUE if e[idx] = 1; otherwise go to NEXT.
REQ-013 MUL computes A = MM(A, Xt), then goes to NEXT.
REQ-014 NEXT: if idx = 0, go to OUT_ISSUE; otherwise decrement idx and go to SQ_ISSUE. idx SHALL never wrap below 0.
REQ-015 OUT computes result = MM(A, 1), then goes to DONE.
REQ-016 DONE SHALL pulse done for 1 cycle and go to IDLE on the next cycle.
REQ-017 mm_m SHALL equal the captured n in all states.
REQ-018 mm_done SHALL be ignored outside *_WAIT states.
REQ-019 mm_done SHALL be sampled no earlier than the cycle after mm_start, so the minimum multiplier latency is 1 cycle.
REQ-020 Overhead excluding multiplier time SHALL be exactly 2 cycles per multiply plus 3 cycles (LOAD, NEXT per bit, DONE accounted separately).

Reset
REQ-021 While reset is high at a clk edge, state SHALL be IDLE and busy, done, error, mm_start SHALL be 0.
REQ-022 Reset SHALL clear result and mm_count to 0.
REQ-023 Reset mid-operation SHALL abandon the operation: no done pulse, and any late mm_done is ignored.

Configuration
REQ-024 Macro MONT_EXP_CONST_TIME_EN.
  Defined: SQ SHALL always be followed by MUL. When e[idx] = 0, the MUL result SHALL be discarded and A kept. Total mm_start count = e_len*2 + 2, independent of exponent value.
  Undefined: behaviour per REQ-012. Total count = e_len + popcount(e[e_len-1:0]) + 2.

Structure
REQ-025 Package mont_pkg SHALL hold the state enum type and the MM_COUNT_W = 16 constant.
REQ-026 The Montgomery multiplier SHALL stay external. The exponent index/bit-select logic SHALL be sub-module mont_exp_scan (load, decrement, current bit, last flag).

Verification
REQ-027 WIDTH=16, multiplier latency 5, N=1009, x=2, e=10, e_len=4 -> result=15. mm_count=8 (=10 with MONT_EXP_CONST_TIME_EN). done pulses once; busy falls the same cycle.
REQ-028 x=3, e=0, e_len=0 -> result=1, mm_count=2, error=0.
REQ-029 e_len=EXP_WIDTH+1 -> done within 2 cycles of start, error=1, result=0, no mm_start pulse.
REQ-030 start pulsed again mid-operation, plus spurious mm_done during SQ_ISSUE -> both ignored; result still correct.
REQ-031 reset asserted during SQ_WAIT -> next cycle IDLE, busy=0, result=0; a following start with x=2, e=10 completes correctly.
REQ-032 Multiplier latency randomised 1..20 over 100 random 16-bit odd moduli -> result matches reference modexp for every case.
